conv_patch_loader: RTL and testbench

Upstream feeder for the convolution engine. For one output pixel it fetches the receptive-field activations of all input channels from the feature-map buffer, applies zero padding at image borders, and writes them into the patch buffer in the engine's layout: `patch[c*K*K + ky*K + kx]`. It pulses `done` when the patch is complete, so the controller can start the conv engine.

---
 rtl/conv_patch_loader.sv | 224 ++++++++++++++++++++++
 tb/tb_conv_patch_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_patch_loader.sv
// conv_patch_loader: gathers one output pixel's receptive field over all input channels
// into the patch buffer as patch[c*K*K + ky*K + kx], writing zeros for taps outside the image.
module conv_patch_loader #(
  parameter int ADDR_W      = 24,
  parameter int PATCH_DEPTH = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [10:0]       c_in,
  input  logic [3:0]        kernel_size,
  input  logic [1:0]        stride,
  input  logic [9:0]        img_w,
  input  logic [9:0]        img_h,
  input  logic [9:0]        out_x,
  input  logic [9:0]        out_y,
  input  logic [ADDR_W-1:0] fmap_base,
  output logic              fmap_rd_en,
  output logic [ADDR_W-1:0] fmap_rd_addr,
  input  logic signed [7:0] fmap_rd_data,
  output logic              patch_wr_en,
  output logic [10:0]       patch_wr_addr,
  output logic signed [7:0] patch_wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  state_t state_r, state_next_s;

  logic [10:0]       c_in_r;
  logic [3:0]        ks_r;
  logic [1:0]        stride_r;
  logic [9:0]        img_w_r, img_h_r, out_x_r, out_y_r;
  logic [ADDR_W-1:0] base_r;

  logic [10:0] c_r, idx_r;
  logic [1:0]  ky_r, kx_r;

  logic              iss_valid_r, iss_pad_r, rd_en_r;
  logic [10:0]       iss_idx_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              wr_en_r, wr_pad_r;
  logic [10:0]       wr_addr_r;
  logic              busy_r, done_r, err_r;

  function automatic logic [3:0] k_sq_of(input logic [3:0] k);
    return (k == 4'd3) ? 4'd9 : 4'd1;
  endfunction

  logic        k3_s, legal_s, oob_s, gen_s, last_issue_s, kx_last_s, ky_last_s;
  logic [11:0] pad_s, iy_s, ix_s;
  logic [14:0] n_s;
  logic [10:0] last_idx_s;
  logic [31:0] lin_s;
  logic [ADDR_W-1:0] addr_s;

  assign k3_s       = (ks_r == 4'd3);
  assign pad_s      = k3_s ? 12'd1 : 12'd0;
  assign n_s        = 15'(c_in_r) * 15'(k_sq_of(ks_r));
  assign legal_s    = ((ks_r == 4'd1) || (ks_r == 4'd3)) &&
                      ((stride_r == 2'd1) || (stride_r == 2'd2)) &&
                      (c_in_r != 11'd0) && (n_s <= 15'(PATCH_DEPTH));
  // A full 2048-entry patch wraps n_s[10:0] to 0, so the -1 still lands on 2047.
  assign last_idx_s = n_s[10:0] - 11'd1;

  // Source coordinates are 12-bit two's complement; bit 11 set means above/left of the image.
  assign iy_s  = 12'(out_y_r) * 12'(stride_r) + 12'(ky_r) - pad_s;
  assign ix_s  = 12'(out_x_r) * 12'(stride_r) + 12'(kx_r) - pad_s;
  assign oob_s = iy_s[11] || (iy_s >= {2'b00, img_h_r}) ||
                 ix_s[11] || (ix_s >= {2'b00, img_w_r});
  assign lin_s  = (32'(c_r) * 32'(img_h_r) + 32'(iy_s)) * 32'(img_w_r) + 32'(ix_s);
  assign addr_s = base_r + ADDR_W'(lin_s);

  assign kx_last_s    = k3_s ? (kx_r == 2'd2) : 1'b1;
  assign ky_last_s    = k3_s ? (ky_r == 2'd2) : 1'b1;
  assign last_issue_s = (iss_idx_r == last_idx_s);
  assign gen_s        = ((state_r == ST_CHECK) && legal_s) ||
                        ((state_r == ST_ISSUE) && !last_issue_s);

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_CHECK;
        else       state_next_s = ST_IDLE;
      end
      ST_CHECK: begin
        if (legal_s) state_next_s = ST_ISSUE;
        else         state_next_s = ST_FINISH;
      end
      ST_ISSUE: begin
        if (last_issue_s) state_next_s = ST_DRAIN;
        else              state_next_s = ST_ISSUE;
      end
      ST_DRAIN:  state_next_s = ST_FINISH;
      ST_FINISH: state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_next_s;
  end

  // Configuration snapshot taken on an accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_in_r   <= 11'd0;
      ks_r     <= 4'd0;
      stride_r <= 2'd0;
      img_w_r  <= 10'd0;
      img_h_r  <= 10'd0;
      out_x_r  <= 10'd0;
      out_y_r  <= 10'd0;
      base_r   <= '0;
    end else if ((state_r == ST_IDLE) && start) begin
      c_in_r   <= c_in;
      ks_r     <= kernel_size;
      stride_r <= stride;
      img_w_r  <= img_w;
      img_h_r  <= img_h;
      out_x_r  <= out_x;
      out_y_r  <= out_y;
      base_r   <= fmap_base;
    end else begin
      c_in_r <= c_in_r;
    end
  end

  // Element walker: kx inner, ky middle, channel outer; points at the next element to issue.
  always_ff @(posedge clk) begin
    if (!rst_n || (state_r == ST_IDLE)) begin
      c_r   <= 11'd0;
      ky_r  <= 2'd0;
      kx_r  <= 2'd0;
      idx_r <= 11'd0;
    end else if (gen_s) begin
      idx_r <= idx_r + 11'd1;
      if (!kx_last_s) begin
        kx_r <= kx_r + 2'd1;
      end else begin
        kx_r <= 2'd0;
        if (!ky_last_s) begin
          ky_r <= ky_r + 2'd1;
        end else begin
          ky_r <= 2'd0;
          c_r  <= c_r + 11'd1;
        end
      end
    end else begin
      idx_r <= idx_r;
    end
  end

  // Issue stage: read strobe plus the pad flag and write index that follow the element.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iss_valid_r <= 1'b0;
      iss_pad_r   <= 1'b0;
      iss_idx_r   <= 11'd0;
      rd_en_r     <= 1'b0;
      rd_addr_r   <= '0;
    end else if (gen_s) begin
      iss_valid_r <= 1'b1;
      iss_pad_r   <= oob_s;
      iss_idx_r   <= idx_r;
      rd_en_r     <= !oob_s;
      rd_addr_r   <= oob_s ? '0 : addr_s;
    end else begin
      iss_valid_r <= 1'b0;
      iss_pad_r   <= 1'b0;
      rd_en_r     <= 1'b0;
      rd_addr_r   <= '0;
    end
  end

  // Write stage: lines up with the read data returning one cycle after the strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en_r   <= 1'b0;
      wr_pad_r  <= 1'b0;
      wr_addr_r <= 11'd0;
    end else begin
      wr_en_r   <= iss_valid_r;
      wr_pad_r  <= iss_pad_r;
      wr_addr_r <= iss_valid_r ? iss_idx_r : 11'd0;
    end
  end

  // Status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      busy_r <= (state_next_s != ST_IDLE);
      done_r <= (state_next_s == ST_FINISH);
      err_r  <= (state_r == ST_CHECK) && !legal_s;
    end
  end

  assign fmap_rd_en    = rd_en_r;
  assign fmap_rd_addr  = rd_addr_r;
  assign patch_wr_en   = wr_en_r;
  assign patch_wr_addr = wr_addr_r;
  assign patch_wr_data = (wr_en_r && !wr_pad_r) ? fmap_rd_data : 8'sd0;
  assign busy          = busy_r;
  assign done          = done_r;
  assign err           = err_r;

endmodule

// File: tb/tb_conv_patch_loader.sv
// Self-checking bench for conv_patch_loader: a loop-based patch model predicts every
// output cycle by cycle, and literal values pin both the model and the observed totals.
module tb_conv_patch_loader;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [10:0]       c_in;
  logic [3:0]        kernel_size;
  logic [1:0]        stride;
  logic [9:0]        img_w, img_h, out_x, out_y;
  logic [23:0]       fmap_base;
  logic              fmap_rd_en;
  logic [23:0]       fmap_rd_addr;
  logic signed [7:0] fmap_rd_data;
  logic              patch_wr_en;
  logic [10:0]       patch_wr_addr;
  logic signed [7:0] patch_wr_data;
  logic              busy, done, err;

  conv_patch_loader #(.ADDR_W(24), .PATCH_DEPTH(2048)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .c_in(c_in), .kernel_size(kernel_size),
    .stride(stride), .img_w(img_w), .img_h(img_h), .out_x(out_x), .out_y(out_y),
    .fmap_base(fmap_base), .fmap_rd_en(fmap_rd_en), .fmap_rd_addr(fmap_rd_addr),
    .fmap_rd_data(fmap_rd_data), .patch_wr_en(patch_wr_en), .patch_wr_addr(patch_wr_addr),
    .patch_wr_data(patch_wr_data), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_val(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
  endfunction

  // Feature-map memory: data one cycle after the strobe, junk otherwise so padding must be forced to 0.
  always @(posedge clk) begin
    fmap_rd_data <= fmap_rd_en ? mem_val(fmap_rd_addr) : 8'sh5A;
  end

  int n_cmp, n_bad;
  int cyc, t0, kill_cyc;
  bit m_legal;
  int m_n;
  bit          m_pad  [0:2047];
  logic [23:0] m_addr [0:2047];
  int obs_rd, obs_wr, obs_done, obs_done_at, obs_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model(input int cin, input int k, input int s, input int w, input int h,
                       input int ox, input int oy, input int base);
    int ksq, pd, idx, iy, ix;
    ksq = (k == 3) ? 9 : 1;
    pd  = (k == 3) ? 1 : 0;
    m_legal = (k == 1 || k == 3) && (s == 1 || s == 2) && (cin != 0) && (cin * ksq <= 2048);
    m_n = m_legal ? cin * ksq : 0;
    if (m_legal) begin
      for (int c = 0; c < cin; c++)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            idx = c * k * k + ky * k + kx;
            iy  = oy * s + ky - pd;
            ix  = ox * s + kx - pd;
            m_pad[11'(idx)]  = (iy < 0) || (iy >= h) || (ix < 0) || (ix >= w);
            m_addr[11'(idx)] = 24'(base + (c * h + iy) * w + ix);
          end
    end
  endtask

  task automatic compare();
    int r, e_done_r;
    bit idle, e_busy, e_done, e_err, e_rd, e_wr;
    logic [10:0] ri, wi;
    logic [7:0] e_wdata;
    r = cyc - t0;
    e_done_r = m_legal ? m_n + 3 : 2;
    idle   = (kill_cyc >= t0) && (cyc > kill_cyc);
    e_busy = !idle && (r >= 1) && (r <= e_done_r);
    e_done = !idle && (r == e_done_r);
    e_err  = e_done && !m_legal;
    e_rd   = 1'b0;
    ri     = 11'd0;
    if (!idle && m_legal && (r >= 2) && (r < m_n + 2)) begin
      ri   = 11'(r - 2);
      e_rd = !m_pad[ri];
    end
    e_wr = !idle && m_legal && (r >= 3) && (r < m_n + 3);
    wi   = 11'(r - 3);
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("err", 32'(err), 32'(e_err));
    chk("rd_en", 32'(fmap_rd_en), 32'(e_rd));
    chk("wr_en", 32'(patch_wr_en), 32'(e_wr));
    if (e_rd) chk("rd_addr", {8'd0, fmap_rd_addr}, {8'd0, m_addr[ri]});
    if (e_wr) begin
      e_wdata = m_pad[wi] ? 8'd0 : mem_val(m_addr[wi]);
      chk("wr_addr", {21'd0, patch_wr_addr}, {21'd0, wi});
      chk("wr_data", {24'd0, patch_wr_data}, {24'd0, e_wdata});
    end
    if (fmap_rd_en === 1'b1) obs_rd++;
    if (patch_wr_en === 1'b1) obs_wr++;
    if (err === 1'b1) obs_err++;
    if (done === 1'b1) begin
      obs_done++;
      obs_done_at = r;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_patch(input int cin, input int k, input int s, input int w, input int h,
                             input int ox, input int oy, input int base);
    c_in = 11'(cin); kernel_size = 4'(k); stride = 2'(s);
    img_w = 10'(w); img_h = 10'(h); out_x = 10'(ox); out_y = 10'(oy);
    fmap_base = 24'(base);
    start = 1'b1;
    model(cin, k, s, w, h, ox, oy, base);
    t0 = cyc;
    kill_cyc = -1000;
    obs_rd = 0; obs_wr = 0; obs_done = 0; obs_done_at = -1; obs_err = 0;
    step();
    start = 1'b0;
    c_in = c_in + 11'd5; kernel_size = ~kernel_size; stride = ~stride;
    img_w = img_w + 10'd3; out_x = out_x + 10'd1; out_y = out_y + 10'd2;
    fmap_base = fmap_base ^ 24'h00F0F0;
  endtask

  // Runs to the earliest cycle a new start may be accepted.
  task automatic finish_patch();
    int e_done_r;
    e_done_r = m_legal ? m_n + 3 : 2;
    while (cyc < t0 + e_done_r + 1) step();
  endtask

  int bad_cin [0:3];
  int bad_k   [0:3];
  int bad_s   [0:3];
  logic [31:0] mask;
  int npad;

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; t0 = -100; kill_cyc = -1000;
    m_legal = 1'b0; m_n = 0;
    obs_rd = 0; obs_wr = 0; obs_done = 0; obs_done_at = -1; obs_err = 0;
    rst_n = 1'b0; start = 1'b0; c_in = 11'd0; kernel_size = 4'd0; stride = 2'd0;
    img_w = 10'd0; img_h = 10'd0; out_x = 10'd0; out_y = 10'd0; fmap_base = 24'd0;
    step(); step();
    rst_n = 1'b1;
    step();

    // K=1, 4 channels, 8x8, (3,2)
    start_patch(4, 1, 1, 8, 8, 3, 2, 'h001000);
    chk("t1_model_addr0", {8'd0, m_addr[0]}, 32'h0000_1013);
    chk("t1_model_addr3", {8'd0, m_addr[3]}, 32'h0000_10D3);
    finish_patch();
    chk("t1_reads", 32'(obs_rd), 32'd4);
    chk("t1_writes", 32'(obs_wr), 32'd4);
    chk("t1_done_at", 32'(obs_done_at), 32'd7);

    // K=3 corner pixel (0,0) of a 4x4 map, 2 channels
    start_patch(2, 3, 1, 4, 4, 0, 0, 'h000200);
    mask = 32'd0;
    for (int i = 0; i < 18; i++) mask[i] = m_pad[11'(i)];
    chk("t2_model_padmask", mask, 32'h0000_9E4F);
    finish_patch();
    chk("t2_reads", 32'(obs_rd), 32'd8);
    chk("t2_writes", 32'(obs_wr), 32'd18);
    chk("t2_done_at", 32'(obs_done_at), 32'd21);

    // K=3 interior (5,5), 16x16, stride 2, 3 channels; base near the top to exercise the wrap
    start_patch(3, 3, 2, 16, 16, 5, 5, 'hFFFF00);
    npad = 0;
    for (int i = 0; i < 27; i++) npad += int'(m_pad[11'(i)]);
    chk("t3_model_npad", 32'(npad), 32'd0);
    chk("t3_model_addr0", {8'd0, m_addr[0]}, 32'h00FF_FF99);
    chk("t3_model_addr26", {8'd0, m_addr[26]}, 32'h0000_01BB);
    finish_patch();
    chk("t3_reads", 32'(obs_rd), 32'd27);
    chk("t3_done_at", 32'(obs_done_at), 32'd30);

    // Illegal configurations
    bad_cin[0] = 4;   bad_k[0] = 2; bad_s[0] = 1;
    bad_cin[1] = 0;   bad_k[1] = 3; bad_s[1] = 1;
    bad_cin[2] = 228; bad_k[2] = 3; bad_s[2] = 1;
    bad_cin[3] = 4;   bad_k[3] = 1; bad_s[3] = 3;
    for (int i = 0; i < 4; i++) begin
      start_patch(bad_cin[i], bad_k[i], bad_s[i], 8, 8, 1, 1, 'h000000);
      chk("ill_model_legal", 32'(m_legal), 32'd0);
      finish_patch();
      chk("ill_reads", 32'(obs_rd), 32'd0);
      chk("ill_writes", 32'(obs_wr), 32'd0);
      chk("ill_err", 32'(obs_err), 32'd1);
      chk("ill_done_at", 32'(obs_done_at), 32'd2);
    end

    // Largest legal patch: 227 channels * 9 = 2043 entries
    start_patch(227, 3, 1, 4, 4, 3, 3, 'h000000);
    chk("big_model_legal", 32'(m_legal), 32'd1);
    finish_patch();
    chk("big_writes", 32'(obs_wr), 32'd2043);
    chk("big_done_at", 32'(obs_done_at), 32'd2046);

    // A second start while busy is ignored
    start_patch(2, 3, 1, 8, 8, 2, 2, 'h000400);
    step(); step();
    c_in = 11'd1; kernel_size = 4'd1; stride = 2'd1; start = 1'b1;
    step();
    start = 1'b0;
    finish_patch();
    chk("t5_writes", 32'(obs_wr), 32'd18);
    chk("t5_done_cnt", 32'(obs_done), 32'd1);
    chk("t5_done_at", 32'(obs_done_at), 32'd21);

    // Reset mid-patch, then a fresh patch
    start_patch(2, 3, 1, 4, 4, 1, 1, 'h000000);
    while (cyc < t0 + 6) step();
    rst_n = 1'b0;
    kill_cyc = cyc;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) step();
    chk("t6_writes_before_reset", 32'(obs_wr), 32'd4);
    chk("t6_no_done", 32'(obs_done), 32'd0);
    start_patch(1, 3, 1, 4, 4, 1, 1, 'h000100);
    finish_patch();
    chk("t6_fresh_writes", 32'(obs_wr), 32'd9);
    chk("t6_fresh_done_at", 32'(obs_done_at), 32'd12);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
